cbus_sram_responder: RTL

Synchronous-SRAM-backed slave for the cache bus (CBus). It accepts single-word and wrapping burst read/write requests from a CBus initiator such as a data buffer or cache, and returns one word per beat with `ready`/`last` handshaking. It sits at the memory end of CBus in simulation and FPGA builds, replacing the external memory controller.

---
 rtl/cbus_sram_responder_pkg.sv | 46 ++++
 rtl/cbus_sram_responder_sync_ram.sv | 36 +++
 rtl/cbus_sram_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus types plus helpers reused by every CBus agent.
// Requests carry a byte address and a wrapping burst length; responses return one word per beat.
package cbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1,
        MSIZE2,
        MSIZE4
    } msize_t;

    typedef enum logic [2:0] {
        MLEN1,
        MLEN2,
        MLEN4,
        MLEN8,
        MLEN16
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    function automatic logic [4:0] mlenToBeats(input mlen_t len);
        case (len)
            MLEN1:   return 5'd1;
            MLEN2:   return 5'd2;
            MLEN4:   return 5'd4;
            MLEN8:   return 5'd8;
            MLEN16:  return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/cbus_sram_responder_sync_ram.sv
// Single-port 32-bit RAM with byte strobes and a 1-cycle registered read.
// On a write, the read port returns the freshly merged word (write-first).
module sync_ram #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            strobe_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;
    logic [31:0] wordMerged;

    always_comb begin
        wordMerged = mem[addr_i];
        for (int b = 0; b < 4; b++) begin
            if (strobe_i[b]) begin
                wordMerged[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wordMerged;
        end
        rdata_q <= we_i ? wordMerged : mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus slave backed by a synchronous SRAM: single-word and wrapping burst reads/writes,
// optional wait cycles before the first beat, and one turnaround cycle after the last beat.
module cbus_sram_responder
    import cbus_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq_i,
    output cbus_resp_t cresp_o
);

    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e                state_q,    state_d;
    logic [CW-1:0]         waitCnt_q,  waitCnt_d;
    logic [3:0]            beatCnt_q,  beatCnt_d;
    logic [4:0]            beats_q,    beats_d;
    logic [ADDR_WIDTH-1:0] startIdx_q, startIdx_d;
    logic                  isWrite_q,  isWrite_d;

    logic [ADDR_WIDTH-1:0] wrapMask;
    logic [ADDR_WIDTH-1:0] curIdx;
    logic [ADDR_WIDTH-1:0] nextIdx;
    logic                  isLastBeat;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic                  ramWe;
    logic [31:0]           ramRdata;

    logic unusedReqBits;
    assign unusedReqBits = ^{creq_i.size, creq_i.addr[1:0], creq_i.addr[31:ADDR_WIDTH+2]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            beatCnt_q  <= '0;
            beats_q    <= '0;
            startIdx_q <= '0;
            isWrite_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            beatCnt_q  <= beatCnt_d;
            beats_q    <= beats_d;
            startIdx_q <= startIdx_d;
            isWrite_q  <= isWrite_d;
        end
    end

    // Beats wrap inside the N-aligned block, so the carry never reaches the upper index bits.
    always_comb begin
        wrapMask   = ADDR_WIDTH'(beats_q - 5'd1);
        curIdx     = (startIdx_q & ~wrapMask) | ((startIdx_q + ADDR_WIDTH'(beatCnt_q)) & wrapMask);
        nextIdx    = (startIdx_q & ~wrapMask) |
                     ((startIdx_q + ADDR_WIDTH'({1'b0, beatCnt_q} + 5'd1)) & wrapMask);
        isLastBeat = ({1'b0, beatCnt_q} == (beats_q - 5'd1));
    end

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        beatCnt_d  = beatCnt_q;
        beats_d    = beats_q;
        startIdx_d = startIdx_q;
        isWrite_d  = isWrite_q;
        ramAddr    = startIdx_q;
        ramWe      = 1'b0;
        cresp_o    = '0;

        case (state_q)
            IDLE: begin
                if (creq_i.valid) begin
                    startIdx_d = creq_i.addr[ADDR_WIDTH+1:2];
                    beats_d    = mlenToBeats(creq_i.len);
                    isWrite_d  = creq_i.is_write;
                    waitCnt_d  = CW'(LATENCY);
                    beatCnt_d  = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                ramAddr = startIdx_q;
                if (waitCnt_q == '0) begin
                    state_d = isWrite_q ? WRITE : READ;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end
            READ: begin
                // Prefetch the following beat so its word is registered by the next cycle.
                ramAddr       = nextIdx;
                cresp_o.ready = 1'b1;
                cresp_o.last  = isLastBeat;
                cresp_o.data  = ramRdata;
                if (isLastBeat) begin
                    state_d = DONE;
                end else begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
            end
            WRITE: begin
                // A reset landing on a beat must not let that beat reach memory.
                ramAddr       = curIdx;
                ramWe         = resetn;
                cresp_o.ready = 1'b1;
                cresp_o.last  = isLastBeat;
                cresp_o.data  = ramRdata;
                if (isLastBeat) begin
                    state_d = DONE;
                end else begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
            end
            DONE: begin
                beatCnt_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sync_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .addr_i  (ramAddr),
        .we_i    (ramWe),
        .strobe_i(creq_i.strobe),
        .wdata_i (creq_i.data),
        .rdata_o (ramRdata)
    );

endmodule
